spi1_cmd: RTL
=============

# spi1_cmd

Command decoder between the SPI1 byte receiver (MCU link) and the FPGA bus arbiter. Parses byte streams framed by /CS into 17-bit-address bus read/write requests. Issues each request over a valid/ack handshake and drives `spi_ready_no` so the MCU knows when the request has completed. Holds the last read byte for return to the MCU on the next SPI transaction.

## Interface
Parameters:
- `ADDR_WIDTH`, 17, bus address width (A16 selects the upper 64 KB).

Ports:
- `clk_i`  in  1  system clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `spi_cs_ni`  in  1  /CS, already synchronized to `clk_i`.
- `rx_valid_i`  in  1  one-cycle pulse: `rx_data_i` holds a completed byte.
- `rx_data_i`  in  8  received byte.
- `tx_data_o`  out  8  byte the receiver shifts out on the next transaction.
- `bus_addr_o`  out  17  request address.
- `bus_data_o`  out  8  write data.
- `bus_we_o`  out  1  1 = write, 0 = read.
- `bus_valid_o`  out  1  request pending.
- `bus_ack_i`  in  1  one-cycle completion strobe. Read data is valid on `bus_data_i` in that cycle.
- `bus_data_i`  in  8  read data.
- `spi_ready_no`  out  1  0 = idle/complete, 1 = command in progress.

## Operation
Command byte encoding:
- bit7 = 1: explicit address. Bit 6 = read (1) / write (0). Bit 0 = A16.
- bit7 = 0: sequential. Address = previous address + 1. Bit 6 = read / write.

Frames:
- WRITE_AT (0x80|A16): cmd, addr_hi, addr_lo, data.
- READ_AT (0xC0|A16): cmd, addr_hi, addr_lo.
- WRITE_NEXT (0x00): cmd, data.
- READ_NEXT (0x40): cmd.

State machine:
- `CMD`:
  - byte received → latch opcode.
  - Explicit address → `ADDR_HI`.
  - WRITE_NEXT → `DATA`.
  - READ_NEXT → `BUS` (address incremented).
- `ADDR_HI` → `ADDR_LO`.
- `ADDR_LO`:
  - Write → `DATA`.
  - Read → `BUS`.
- `DATA` → `BUS`.
- `BUS`:
  - `bus_valid_o` = 1.
  - On `bus_ack_i`: if read, latch `bus_data_i` into `tx_data_o`; then → `DONE`.
- `DONE`:
  - Bytes are ignored.
  - `spi_ready_no` = 0.
  - `spi_cs_ni` = 1 → `CMD`.

Rules:
- `spi_cs_ni` = 1 in any state other than `BUS` → abort, go to `CMD`, and `spi_ready_no` = 0. Partial address bytes already received are discarded; the address register is unchanged.
- `spi_cs_ni` = 1 in `BUS` → the request completes normally, then go to `CMD` without visiting `DONE`.
- Address increment wraps modulo 2^17: 0x1FFFF → 0x00000.
- The address register is updated only when a request is issued.
- `spi_ready_no` rises in the cycle after `spi_cs_ni` falls. It falls in the cycle after `bus_ack_i`.

## Timing
- Reset values: `tx_data_o` = 0x00, `bus_addr_o` = 0, `bus_data_o` = 0x00, `bus_we_o` = 0, `bus_valid_o` = 0, `spi_ready_no` = 0. State = `CMD`.
- `bus_valid_o` asserts 1 cycle after the final byte's `rx_valid_i`.
- `bus_addr_o`, `bus_data_o` and `bus_we_o` are registered and stable from `bus_valid_o` rising until the ack.
- `bus_valid_o` deasserts in the cycle after `bus_ack_i`. The ack may arrive in the first `bus_valid_o` cycle (zero wait) or any number of cycles later.
- A `bus_ack_i` that arrives while `bus_valid_o` = 0 is ignored.
- `rx_valid_i` and a `spi_cs_ni` rise in the same cycle: /CS wins and the byte is discarded.
- `rx_valid_i` during `BUS` or `DONE` is ignored.
- Reset asserted mid-request: all outputs return to their reset values immediately and any pending request is dropped.

## Structure
- Package `spi1_cmd_pkg`:
  - opcode bit positions and constants (`CMD_EXPLICIT` = bit7, `CMD_READ` = bit6);
  - state enum `spi1_cmd_state_t`;
  - `ADDR_WIDTH` default.
- Single flat module; no sub-module is warranted.
- The byte shifter (`spi1_target`) stays separate, upstream of this block.

## Test plan
- WRITE_AT: bytes 0x81, 0x23, 0x45, 0xA5 → one request: addr 0x12345, we = 1, data 0xA5. `spi_ready_no` falls 1 cycle after ack.
- READ_AT then retrieve: bytes 0xC0, 0x80, 0x00, with `bus_data_i` = 0x3C on ack after 3 wait cycles → `tx_data_o` = 0x3C, which persists across the next /CS frame.
- Sequential writes: WRITE_AT 0x1FFFF, then WRITE_NEXT data 0x11 → second request at addr 0x00000 (wrap).
- Abort: /CS raised after 0x80, 0x12 → no request issued, `spi_ready_no` = 0, the next READ_NEXT uses the previous address + 1.
- /CS raised in `BUS` with ack delayed 5 cycles → request held stable until ack, then `CMD`; a following frame decodes normally.
- `reset_ni` pulsed low while `bus_valid_o` = 1 → all outputs at reset values within the same cycle, and a late `bus_ack_i` is ignored.

Source files
------------

// File: rtl/spi1_cmd_pkg.sv
// Shared opcode layout, FSM state type and default sizing for the SPI1 command decoder.
package spi1_cmd_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 17;

  // Command byte bit positions
  localparam int unsigned CMD_EXPLICIT = 7;
  localparam int unsigned CMD_READ     = 6;
  localparam int unsigned CMD_A16      = 0;

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_BUS     = 3'd4,
    ST_DONE    = 3'd5
  } spi1_cmd_state_t;

endpackage

// File: rtl/spi1_cmd.sv
// SPI1 command decoder: turns /CS-framed byte streams from the MCU link into
// bus read/write requests with a valid/ack handshake and a busy flag back to the MCU.
module spi1_cmd
  import spi1_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  spi_cs_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic [7:0]            tx_data_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [7:0]            bus_data_o,
  output logic                  bus_we_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ack_i,
  input  logic [7:0]            bus_data_i,
  output logic                  spi_ready_no
);

  spi1_cmd_state_t state_q, state_d;

  // Opcode fields and partial address captured while the frame is arriving
  logic       explicit_q, rd_q, a16_q;
  logic [7:0] hi_q, lo_q;

  // Request registers (drive the bus directly)
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q, tx_q;
  logic                  we_q, ready_q;

  // Next-state decode results
  logic                  ready_d;
  logic                  lat_op, lat_hi, lat_lo, issue, capture_rd;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_we;
  logic [7:0]            issue_data;

  // Next-state and load-enable decode; /CS abort outranks any byte in the same cycle
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    lat_op     = 1'b0;
    lat_hi     = 1'b0;
    lat_lo     = 1'b0;
    issue      = 1'b0;
    capture_rd = 1'b0;
    issue_addr = addr_q;
    issue_we   = we_q;
    issue_data = wdata_q;

    if (state_q == ST_BUS) begin
      // A started request always runs to its ack, even if /CS has risen
      if (bus_ack_i) begin
        capture_rd = ~we_q;
        ready_d    = 1'b0;
        state_d    = spi_cs_ni ? ST_CMD : ST_DONE;
      end
    end else if (spi_cs_ni) begin
      state_d = ST_CMD;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          ready_d = 1'b1;
          if (rx_valid_i) begin
            lat_op = 1'b1;
            if (rx_data_i[CMD_EXPLICIT]) begin
              state_d = ST_ADDR_HI;
            end else if (rx_data_i[CMD_READ]) begin
              issue      = 1'b1;
              issue_addr = addr_q + 1'b1;
              issue_we   = 1'b0;
              state_d    = ST_BUS;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_ADDR_HI: begin
          ready_d = 1'b1;
          if (rx_valid_i) begin
            lat_hi  = 1'b1;
            state_d = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          ready_d = 1'b1;
          if (rx_valid_i) begin
            lat_lo = 1'b1;
            if (rd_q) begin
              issue      = 1'b1;
              issue_addr = ADDR_WIDTH'({a16_q, hi_q, rx_data_i});
              issue_we   = 1'b0;
              state_d    = ST_BUS;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          ready_d = 1'b1;
          if (rx_valid_i) begin
            issue      = 1'b1;
            issue_addr = explicit_q ? ADDR_WIDTH'({a16_q, hi_q, lo_q}) : addr_q + 1'b1;
            issue_we   = 1'b1;
            issue_data = rx_data_i;
            state_d    = ST_BUS;
          end
        end
        ST_DONE: begin
          ready_d = 1'b0;
        end
        default: begin
          state_d = ST_CMD;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // State register and ready flag
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_CMD;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Frame capture registers; partial addresses never touch addr_q until a request issues
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      explicit_q <= 1'b0;
      rd_q       <= 1'b0;
      a16_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (lat_op) begin
        explicit_q <= rx_data_i[CMD_EXPLICIT];
        rd_q       <= rx_data_i[CMD_READ];
        a16_q      <= rx_data_i[CMD_A16];
      end
      if (lat_hi) hi_q <= rx_data_i;
      if (lat_lo) lo_q <= rx_data_i;
    end
  end

  // Request registers, loaded once per issued request and held until the next one
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      tx_q    <= '0;
    end else begin
      if (issue) begin
        addr_q  <= issue_addr;
        wdata_q <= issue_data;
        we_q    <= issue_we;
      end
      if (capture_rd) tx_q <= bus_data_i;
    end
  end

  assign bus_valid_o  = (state_q == ST_BUS);
  assign bus_addr_o   = addr_q;
  assign bus_data_o   = wdata_q;
  assign bus_we_o     = we_q;
  assign tx_data_o    = tx_q;
  assign spi_ready_no = ready_q;

endmodule
